tdm_demux_receiver: RTL and testbench

- Receive end of a time-division-multiplexed 4-bit link. A sender scans four sources onto one data bus, one slot per beat, and marks slot 0 with a start-of-frame strobe.
- This block tracks the slot position with a counter and FSM, then demultiplexes each beat into one of four registered destination outputs.
- It reports frame completion and framing errors. It sits between the board switch/button link and the LED destination groups.

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_decoder.sv | 17 +
 rtl/tdm_demux_receiver.sv | 138 +++++++++++++
 tb/tb_tdm_demux_receiver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: the sender (tdm_mux_sender) and the receiver
// (tdm_demux_receiver) both import this package.
package tdm_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam slot_t SLOT_FIRST = 2'd0;
    localparam slot_t SLOT_LAST  = 2'd3;

endpackage

// File: rtl/tdm_slot_decoder.sv
// Turns a slot index plus a write strobe into a one-hot write enable.
// There is one enable bit per destination register, or per shadow register.
module tdm_slot_decoder
    import tdm_pkg::*;
#(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  slot_t                slot,
    input  logic                 wr_strobe,
    output logic [NUM_SLOTS-1:0] wr_en
);

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_dec
        assign wr_en[gi] = wr_strobe && (slot == slot_t'(gi));
    end

endmodule

// File: rtl/tdm_demux_receiver.sv
// Receive end of the 4-slot TDM link: it tracks the slot position and demultiplexes beats onto y1..y4.
// Optional TDM_DOUBLE_BUFFER_EN stages beats in shadow registers and publishes whole frames only.
module tdm_demux_receiver
    import tdm_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [1:0]       slot,
    output logic             frame_done,
    output logic             frame_err
);

    state_t state_q, state_d;
    slot_t  slot_q, slot_d;
    logic   done_q, done_d;
    logic   err_q, err_d;
    logic   beat;
    logic   wr_strobe;
    slot_t  wr_slot;
    logic [NUM_SLOTS-1:0] wr_en;

    assign beat = enable && in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            slot_q  <= SLOT_FIRST;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (beat) begin
            if (in_sof) begin
                state_d = RECV;
                slot_d  = slot_t'(SLOT_FIRST + 2'd1);
            end else if (state_q == RECV) begin
                if (slot_q == SLOT_LAST) begin
                    state_d = IDLE;
                    slot_d  = SLOT_FIRST;
                end else begin
                    slot_d = slot_t'(slot_q + 2'd1);
                end
            end
        end
    end

    // An sof always lands on slot 0. If a frame was already open, that frame is abandoned.
    always_comb begin
        wr_strobe = 1'b0;
        wr_slot   = slot_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (beat) begin
            if (in_sof) begin
                wr_strobe = 1'b1;
                wr_slot   = SLOT_FIRST;
                err_d     = (state_q == RECV);
            end else if (state_q == RECV) begin
                wr_strobe = 1'b1;
                done_d    = (slot_q == SLOT_LAST);
            end else begin
                err_d = 1'b1;
            end
        end
    end

    tdm_slot_decoder #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_slot_decoder (
        .slot      (wr_slot),
        .wr_strobe (wr_strobe),
        .wr_en     (wr_en)
    );

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_dest
        logic [WIDTH-1:0] y_q, y_d;
`ifdef TDM_DOUBLE_BUFFER_EN
        logic [WIDTH-1:0] shadow_q, shadow_d;

        // Publish on the completing edge, using shadow_d so that slot-3 data from that same beat is included.
        always_comb begin
            shadow_d = wr_en[gi] ? in_data : shadow_q;
            y_d      = done_d ? shadow_d : y_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                shadow_q <= '0;
                y_q      <= '0;
            end else begin
                shadow_q <= shadow_d;
                y_q      <= y_d;
            end
        end
`else
        always_comb begin
            y_d = wr_en[gi] ? in_data : y_q;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                y_q <= '0;
            end else begin
                y_q <= y_d;
            end
        end
`endif
    end

    assign y1         = g_dest[0].y_q;
    assign y2         = g_dest[1].y_q;
    assign y3         = g_dest[2].y_q;
    assign y4         = g_dest[3].y_q;
    assign slot       = slot_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_tdm_demux_receiver.sv
// Directed vector bench for tdm_demux_receiver: a table of hand-computed vectors and a paused-frame sequence.
// The expected outputs follow TDM_DOUBLE_BUFFER_EN when that macro is defined.
module tb_tdm_demux_receiver;

    logic       clk = 1'b0;
    logic       reset, enable, in_valid, in_sof;
    logic [3:0] in_data;
    logic [3:0] y1, y2, y3, y4;
    logic [1:0] slot;
    logic       frame_done, frame_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tdm_demux_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y4         (y4),
        .slot       (slot),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    // ey/eyb hold {y4,y3,y2,y1}: ey for per-slot update, eyb for the double-buffered build.
    typedef struct {
        logic        rst, en, val, sof;
        logic [3:0]  data;
        logic [15:0] ey, eyb;
        logic [1:0]  eslot;
        logic        edone, eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, en, val, sof, input logic [3:0] data,
                                input logic [15:0] ey, eyb, input logic [1:0] eslot,
                                input logic edone, eerr);
        vec_t v;
        v.rst = rst; v.en = en; v.val = val; v.sof = sof; v.data = data;
        v.ey = ey; v.eyb = eyb; v.eslot = eslot; v.edone = edone; v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [15:0] ey, input logic [1:0] es,
                         input logic ed, input logic ee);
        logic [15:0] ay;
        ay = {y4, y3, y2, y1};
        n_vec++;
        if (ay !== ey || slot !== es || frame_done !== ed || frame_err !== ee) begin
            n_bad++;
            $display("FAIL %s: got y=%h slot=%0d done=%b err=%b, want y=%h slot=%0d done=%b err=%b",
                     name, ay, slot, frame_done, frame_err, ey, es, ed, ee);
        end else begin
            $display("ok   %s: y=%h slot=%0d done=%b err=%b", name, ay, slot, frame_done, frame_err);
        end
    endtask

    task automatic drive(input logic rst, en, val, sof, input logic [3:0] data);
        reset = rst; enable = en; in_valid = val; in_sof = sof; in_data = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] want;
        int          waited;

        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 4'h0;

        //   rst en val sof data  ey        eyb       slot done err
        add(1, 0, 0, 0, 4'h0, 16'h0000, 16'h0000, 2'd0, 0, 0);  // reset
        add(0, 1, 1, 1, 4'hA, 16'h000A, 16'h0000, 2'd1, 0, 0);  // full frame A..D
        add(0, 1, 1, 0, 4'hB, 16'h00BA, 16'h0000, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'hC, 16'h0CBA, 16'h0000, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'hD, 16'hDCBA, 16'hDCBA, 2'd0, 1, 0);
        add(0, 1, 0, 0, 4'h0, 16'hDCBA, 16'hDCBA, 2'd0, 0, 0);
        add(0, 1, 1, 0, 4'h5, 16'hDCBA, 16'hDCBA, 2'd0, 0, 1);  // stray beat
        add(0, 0, 1, 0, 4'h5, 16'hDCBA, 16'hDCBA, 2'd0, 0, 0);  // gated stray: no err
        add(0, 1, 1, 1, 4'h1, 16'hDCB1, 16'hDCBA, 2'd1, 0, 0);  // mid-frame resync
        add(0, 1, 1, 0, 4'h2, 16'hDC21, 16'hDCBA, 2'd2, 0, 0);
        add(0, 1, 1, 1, 4'h7, 16'hDC27, 16'hDCBA, 2'd1, 0, 1);
        add(0, 1, 1, 0, 4'h8, 16'hDC87, 16'hDCBA, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'h9, 16'hD987, 16'hDCBA, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'h3, 16'h3987, 16'h3987, 2'd0, 1, 0);
        add(0, 0, 0, 0, 4'h0, 16'h3987, 16'h3987, 2'd0, 0, 0);
        add(0, 1, 1, 1, 4'hE, 16'h398E, 16'h3987, 2'd1, 0, 0);  // enable gating
        add(0, 1, 1, 0, 4'hF, 16'h39FE, 16'h3987, 2'd2, 0, 0);
        add(0, 0, 1, 0, 4'h1, 16'h39FE, 16'h3987, 2'd2, 0, 0);
        add(0, 0, 1, 1, 4'h2, 16'h39FE, 16'h3987, 2'd2, 0, 0);
        add(0, 0, 1, 0, 4'h3, 16'h39FE, 16'h3987, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'h6, 16'h36FE, 16'h3987, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'h4, 16'h46FE, 16'h46FE, 2'd0, 1, 0);
        add(0, 1, 0, 1, 4'h9, 16'h46FE, 16'h46FE, 2'd0, 0, 0);  // sof without valid
        add(0, 1, 1, 1, 4'h1, 16'h46F1, 16'h46FE, 2'd1, 0, 0);  // reset mid-frame
        add(0, 1, 1, 0, 4'h2, 16'h4621, 16'h46FE, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'h3, 16'h4321, 16'h46FE, 2'd3, 0, 0);
        add(1, 1, 1, 0, 4'h5, 16'h0000, 16'h0000, 2'd0, 0, 0);
        add(0, 1, 1, 1, 4'hA, 16'h000A, 16'h0000, 2'd1, 0, 0);
        add(0, 1, 1, 0, 4'hB, 16'h00BA, 16'h0000, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'hC, 16'h0CBA, 16'h0000, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'hD, 16'hDCBA, 16'hDCBA, 2'd0, 1, 0);
        add(0, 1, 1, 1, 4'h1, 16'hDCB1, 16'hDCBA, 2'd1, 0, 0);  // back-to-back frames
        add(0, 1, 1, 0, 4'h2, 16'hDC21, 16'hDCBA, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'h3, 16'hD321, 16'hDCBA, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'h4, 16'h4321, 16'h4321, 2'd0, 1, 0);
        add(0, 1, 1, 1, 4'h5, 16'h4325, 16'h4321, 2'd1, 0, 0);
        add(0, 1, 1, 0, 4'h6, 16'h4365, 16'h4321, 2'd2, 0, 0);
        add(0, 1, 1, 0, 4'h7, 16'h4765, 16'h4321, 2'd3, 0, 0);
        add(0, 1, 1, 0, 4'h8, 16'h8765, 16'h8765, 2'd0, 1, 0);
        add(0, 1, 0, 0, 4'h0, 16'h8765, 16'h8765, 2'd0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].val, vecs[i].sof, vecs[i].data);
`ifdef TDM_DOUBLE_BUFFER_EN
            want = vecs[i].eyb;
`else
            want = vecs[i].ey;
`endif
            check($sformatf("vec%0d", i), want, vecs[i].eslot, vecs[i].edone, vecs[i].eerr);
        end

        // Long pause mid-frame: the frame has no timeout and resumes where it left off.
        drive(0, 1, 1, 1, 4'hC);
        drive(0, 1, 1, 0, 4'hD);
        for (int k = 0; k < 20; k++) drive(0, 0, k[0], k[1], 4'(k));
`ifdef TDM_DOUBLE_BUFFER_EN
        want = 16'h8765;
`else
        want = 16'h87DC;
`endif
        check("pause_hold", want, 2'd2, 1'b0, 1'b0);
        drive(0, 1, 1, 0, 4'hE);
        reset = 1'b0; enable = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = 4'hF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waited = 0;
        while (frame_done !== 1'b1 && waited < 5) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_vec++;
        if (waited != 0) begin
            n_bad++;
            $display("FAIL pause_done_latency: got %0d extra cycles, want 0", waited);
        end
        check("pause_done", 16'hFEDC, 2'd0, 1'b1, 1'b0);
        drive(0, 1, 0, 0, 4'h0);
        check("pause_pulse_end", 16'hFEDC, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
